mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning core data width.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning core address width; the MSB selects the config space.
REQ-003 SHALL have parameter RAM_ADDR_W, default 25, meaning SDRAM address width.
REQ-004 SHALL have parameters ROM_BASE 'hD000 and ROM_DEPTH 2048, meaning the bootloader ROM window.
REQ-005 SHALL have parameters FB_BASE 'hE000, FB_DEPTH 4800 and FB_DATA_W 8, meaning the framebuffer window.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the RAM wait limit.
REQ-007 SHALL have ports, one per line (name direction width meaning):
 clk  in  1  core clock (single clock; reset is asynchronous and active-low)
 rst_n  in  1  asynchronous active-low reset
 req_valid  in  1  core request valid
 req_ready  out  1  unit idle, request accepted when high with req_valid
 req_write  in  1  1=write 0=read
 req_addr  in  ADDR_W  core address
 req_wdata  in  DATA_W  write data
 rsp_valid  out  1  one-cycle completion pulse
 rsp_rdata  out  DATA_W  read data, valid with rsp_valid
 rsp_err  out  1  unmapped access or timeout, valid with rsp_valid
 ram_rd_enable  out  1  SDRAM read strobe
 ram_rd_addr  out  RAM_ADDR_W  SDRAM read address
 ram_rd_data  in  DATA_W  SDRAM read data
 ram_rd_ready  in  1  SDRAM read data valid
 ram_wr_enable  out  1  SDRAM write strobe
 ram_wr_addr  out  RAM_ADDR_W  SDRAM write address
 ram_wr_data  out  DATA_W  SDRAM write data
 ram_busy  in  1  SDRAM controller busy
 rom_addr  out  clog2(ROM_DEPTH)  synchronous ROM address (1-cycle read latency)
 rom_data  in  DATA_W  ROM data
 fb_addr  out  clog2(FB_DEPTH)  framebuffer address
 fb_data  out  FB_DATA_W  framebuffer data
 fb_we  out  1  framebuffer write strobe

Function
REQ-008 SHALL decode the address latched on acceptance: MSB=0 is RAM; MSB=1 with ROM_BASE<=addr<ROM_BASE+ROM_DEPTH is ROM; MSB=1 with FB_BASE<=addr<FB_BASE+FB_DEPTH is FB; anything else is UNMAPPED.
REQ-009 SHALL use states IDLE, RAM_RD_ISSUE, RAM_RD_WAIT, RAM_WR_ISSUE, ROM_RD, ROM_CAP and RESP; req_ready SHALL be high only in IDLE.
REQ-010 SHALL route, on an accept in cycle 0: RAM read to RAM_RD_ISSUE; RAM write to RAM_WR_ISSUE; ROM read to ROM_RD; FB write, ROM write, FB read and UNMAPPED to RESP.
REQ-011 For a FB write, SHALL drive fb_we=1 in cycle 1 only, with fb_addr=addr-FB_BASE and fb_data=wdata[FB_DATA_W-1:0].
REQ-012 SHALL complete FB writes in RESP at cycle 1 with rsp_err=0; ROM writes, FB reads and UNMAPPED accesses complete there with rsp_err=1 and rsp_rdata=0, with no side effects.
REQ-013 In ROM_RD (cycle 1), SHALL drive rom_addr=addr-ROM_BASE; ROM_CAP SHALL capture rom_data; rsp_valid SHALL follow in cycle 3.
REQ-014 In RAM_*_ISSUE, SHALL pulse the enable for exactly one cycle, in the first cycle with ram_busy=0.
REQ-015 SHALL zero-extend the address to RAM_ADDR_W, and SHALL set ram_wr_data=wdata.
REQ-016 After the write pulse, SHALL complete in the next cycle with rsp_err=0.
REQ-017 After the read pulse, SHALL wait in RAM_RD_WAIT for ram_rd_ready=1, capture ram_rd_data, and complete in the next cycle with rsp_err=0.
REQ-018 SHALL count cycles spent in RAM_*_ISSUE and RAM_RD_WAIT; on reaching TIMEOUT_CYCLES it SHALL complete with rsp_err=1 and rsp_rdata=0, and the counter SHALL clear on every accept.
REQ-019 If ram_rd_ready coincides with the timeout cycle, the data SHALL win (rsp_err=0).
REQ-020 SHALL ignore ram_rd_ready outside RAM_RD_WAIT, so that stale ready after a timeout is never captured.
REQ-021 RESP SHALL last one cycle, then return to IDLE; a back-to-back request SHALL be accepted in the cycle after RESP.
REQ-022 SHALL hold rsp_rdata and rsp_err stable until the next rsp_valid.
REQ-023 SHALL register all outputs except req_ready; there is no response backpressure.

Reset
REQ-024 While rst_n=0, SHALL force state to IDLE, req_ready=1 and all other outputs and the counter to 0, asynchronously; deassertion SHALL be synchronous to clk.
REQ-025 Reset mid-operation SHALL discard the pending request with no rsp_valid, and enables SHALL drop immediately.

Structure
REQ-026 The state enum, region enum and default window constants SHALL reside in package mcpc_mem_pkg.
REQ-027 Address decode SHALL be a combinational sub-module mem_region_decoder, parametrised by window bases and depths.

Verification
REQ-028 RAM read 'h0123 with ram_busy=1 for 3 cycles, then rd_ready 4 cycles after enable with data 'hBEEF -> one enable pulse, ram_rd_addr 'h0000123, rsp_rdata 'hBEEF, rsp_err=0.
REQ-029 Read 'hD005 with rom_data='h1234 -> rom_addr 5, rsp_valid in cycle 3, rsp_rdata 'h1234.
REQ-030 Write 'hF2BF data 'hA55A -> fb_we pulse, fb_addr 4799, fb_data 'h5A; write 'hF2C0 -> no fb_we, rsp_err=1.
REQ-031 RAM read with rd_ready never asserted, TIMEOUT_CYCLES=8 -> rsp_err=1, rsp_rdata 0; a late rd_ready in IDLE has no effect.
REQ-032 rst_n pulled low during RAM_RD_WAIT -> outputs cleared, no rsp_valid; the next request completes normally.
REQ-033 Back-to-back FB writes with req_valid held -> accepted every 2 cycles.

Source files
------------

// File: rtl/mcpc_mem_pkg.sv
// mcpc_mem_pkg: shared FSM/region types and default address windows for the memory access unit
package mcpc_mem_pkg;
  typedef enum logic [2:0] {IDLE, RAM_RD_ISSUE, RAM_RD_WAIT, RAM_WR_ISSUE, ROM_RD, ROM_CAP, RESP} state_t;
  typedef enum logic [1:0] {REG_RAM, REG_ROM, REG_FB, REG_UNMAPPED} region_t;
  localparam int unsigned DEF_ROM_BASE  = 32'hD000;
  localparam int unsigned DEF_ROM_DEPTH = 2048;
  localparam int unsigned DEF_FB_BASE   = 32'hE000;
  localparam int unsigned DEF_FB_DEPTH  = 4800;
endpackage

// File: rtl/mem_region_decoder.sv
// mem_region_decoder: maps a core address onto RAM, ROM, framebuffer or unmapped space
module mem_region_decoder import mcpc_mem_pkg::*; #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned ROM_BASE  = DEF_ROM_BASE,
  parameter int unsigned ROM_DEPTH = DEF_ROM_DEPTH,
  parameter int unsigned FB_BASE   = DEF_FB_BASE,
  parameter int unsigned FB_DEPTH  = DEF_FB_DEPTH
) (
  input  logic [ADDR_W-1:0] addr_i,
  output region_t           region_o
);
  logic [31:0] a;
  assign a = 32'(addr_i);
  // MSB clear is RAM; config space is split into the ROM and framebuffer windows
  always_comb region_o = !addr_i[ADDR_W-1] ? REG_RAM :
                         (a >= ROM_BASE && a < ROM_BASE + ROM_DEPTH) ? REG_ROM :
                         (a >= FB_BASE && a < FB_BASE + FB_DEPTH) ? REG_FB : REG_UNMAPPED;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: routes single core requests to SDRAM, boot ROM or framebuffer with timeout
module mem_access_unit import mcpc_mem_pkg::*; #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned RAM_ADDR_W     = 25,
  parameter int unsigned ROM_BASE       = DEF_ROM_BASE,
  parameter int unsigned ROM_DEPTH      = DEF_ROM_DEPTH,
  parameter int unsigned FB_BASE        = DEF_FB_BASE,
  parameter int unsigned FB_DEPTH       = DEF_FB_DEPTH,
  parameter int unsigned FB_DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned ROM_AW = $clog2(ROM_DEPTH),
  localparam int unsigned FB_AW  = $clog2(FB_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_rd_enable,
  output logic [RAM_ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0]     ram_rd_data,
  input  logic                  ram_rd_ready,
  output logic                  ram_wr_enable,
  output logic [RAM_ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0]     ram_wr_data,
  input  logic                  ram_busy,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_data,
  output logic [FB_AW-1:0]      fb_addr,
  output logic [FB_DATA_W-1:0]  fb_data,
  output logic                  fb_we
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  state_t                  state_q, state_d;
  region_t                 region;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                    rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [RAM_ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;
  logic [ROM_AW-1:0]       rom_addr_q, rom_addr_d;
  logic [FB_AW-1:0]        fb_addr_q, fb_addr_d;
  logic [FB_DATA_W-1:0]    fb_data_q, fb_data_d;
  logic                    fb_we_q, fb_we_d;
  logic                    done, done_err, timeout;
  logic [DATA_W-1:0]       done_data;

  mem_region_decoder #(
    .ADDR_W(ADDR_W), .ROM_BASE(ROM_BASE), .ROM_DEPTH(ROM_DEPTH), .FB_BASE(FB_BASE), .FB_DEPTH(FB_DEPTH)
  ) u_dec (
    .addr_i(req_addr),
    .region_o(region)
  );

  assign timeout = cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1);

  // next state and registered-output values; completion of any path funnels through done
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d = rsp_err_q;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rom_addr_d = rom_addr_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    fb_we_d = 1'b0;
    done = 1'b0;
    done_err = 1'b0;
    done_data = '0;
    case (state_q)
      IDLE: if (req_valid) begin
        cnt_d = '0;
        if (region == REG_RAM) begin
          state_d = req_write ? RAM_WR_ISSUE : RAM_RD_ISSUE;
          rd_addr_d = req_write ? rd_addr_q : RAM_ADDR_W'(req_addr);
          wr_addr_d = req_write ? RAM_ADDR_W'(req_addr) : wr_addr_q;
          wr_data_d = req_write ? req_wdata : wr_data_q;
        end else if (region == REG_ROM && !req_write) begin
          state_d = ROM_RD;
          rom_addr_d = ROM_AW'(32'(req_addr) - ROM_BASE);
        end else begin
          done = 1'b1;
          done_err = !(region == REG_FB && req_write);
          fb_we_d = !done_err;
          fb_addr_d = done_err ? fb_addr_q : FB_AW'(32'(req_addr) - FB_BASE);
          fb_data_d = done_err ? fb_data_q : req_wdata[FB_DATA_W-1:0];
        end
      end
      RAM_RD_ISSUE, RAM_WR_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (rd_en_q || wr_en_q) begin
          if (state_q == RAM_WR_ISSUE) done = 1'b1;
          else state_d = RAM_RD_WAIT;
        end else if (timeout) begin
          done = 1'b1;
          done_err = 1'b1;
        end else if (!ram_busy) begin
          rd_en_d = state_q == RAM_RD_ISSUE;
          wr_en_d = state_q == RAM_WR_ISSUE;
        end
      end
      RAM_RD_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        done = ram_rd_ready || timeout;
        done_err = !ram_rd_ready;
        done_data = ram_rd_ready ? ram_rd_data : '0;
      end
      ROM_RD: state_d = ROM_CAP;
      ROM_CAP: begin
        done = 1'b1;
        done_data = rom_data;
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = RESP;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = done_err ? '0 : done_data;
      rsp_err_d = done_err;
    end
  end

  // state and output registers, cleared asynchronously so strobes drop the moment reset asserts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rom_addr_q <= '0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      fb_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rom_addr_q <= rom_addr_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      fb_we_q <= fb_we_d;
    end
  end

  assign req_ready = state_q == IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
  assign ram_rd_enable = rd_en_q;
  assign ram_rd_addr = rd_addr_q;
  assign ram_wr_enable = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign rom_addr = rom_addr_q;
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;
  assign fb_we = fb_we_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of decode, ROM/FB/RAM paths, timeout and reset behaviour
module tb_mem_access_unit;
  logic clk, rst_n;
  logic req_valid, t_valid, req_write, ram_rd_ready, ram_busy;
  logic [15:0] req_addr, req_wdata, ram_rd_data, rom_data;
  logic req_ready, rsp_valid, rsp_err, ram_rd_enable, ram_wr_enable, fb_we;
  logic [15:0] rsp_rdata, ram_wr_data;
  logic [24:0] ram_rd_addr, ram_wr_addr;
  logic [10:0] rom_addr;
  logic [12:0] fb_addr;
  logic [7:0] fb_data;
  logic t_req_ready, t_rsp_valid, t_rsp_err, t_ram_rd_enable, t_ram_wr_enable, t_fb_we;
  logic [15:0] t_rsp_rdata, t_ram_wr_data;
  logic [24:0] t_ram_rd_addr, t_ram_wr_addr;
  logic [10:0] t_rom_addr;
  logic [12:0] t_fb_addr;
  logic [7:0] t_fb_data;
  int vectors = 0, miscompares = 0;
  int en_cnt, en_cyc, rc;
  logic [24:0] ra;
  logic [15:0] rd;
  logic er;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_rd_enable(ram_rd_enable), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .ram_rd_ready(ram_rd_ready), .ram_wr_enable(ram_wr_enable),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_busy(ram_busy),
    .rom_addr(rom_addr), .rom_data(rom_data), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(t_valid), .req_ready(t_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata),
    .rsp_err(t_rsp_err), .ram_rd_enable(t_ram_rd_enable), .ram_rd_addr(t_ram_rd_addr),
    .ram_rd_data(ram_rd_data), .ram_rd_ready(ram_rd_ready), .ram_wr_enable(t_ram_wr_enable),
    .ram_wr_addr(t_ram_wr_addr), .ram_wr_data(t_ram_wr_data), .ram_busy(ram_busy),
    .rom_addr(t_rom_addr), .rom_data(rom_data), .fb_addr(t_fb_addr), .fb_data(t_fb_data), .fb_we(t_fb_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
  endtask

  logic [16:0] err_tab [5] = '{{1'b1, 16'hD005}, {1'b0, 16'hE000}, {1'b0, 16'hC000}, {1'b0, 16'hD800}, {1'b1, 16'hF2C0}};

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; t_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    ram_rd_ready = 1'b0; ram_busy = 1'b0; ram_rd_data = '0; rom_data = '0;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rd_en", ram_rd_enable, 0);
    chk("rst_fb_we", fb_we, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    req(1'b0, 16'hD005, 16'h0);
    tick;
    req_valid = 1'b0;
    rom_data = 16'h1234;
    chk("rom_busy", req_ready, 0);
    chk("rom_addr", rom_addr, 5);
    tick;
    chk("rom_c2_valid", rsp_valid, 0);
    tick;
    chk("rom_c3_valid", rsp_valid, 1);
    chk("rom_rdata", rsp_rdata, 16'h1234);
    chk("rom_err", rsp_err, 0);
    tick;
    chk("rom_c4_valid", rsp_valid, 0);
    chk("rom_hold", rsp_rdata, 16'h1234);
    chk("rom_idle", req_ready, 1);
    req(1'b0, 16'hD7FF, 16'h0);
    tick;
    req_valid = 1'b0;
    rom_data = 16'h4321;
    chk("rom_last_addr", rom_addr, 2047);
    tick; tick;
    chk("rom_last_rdata", rsp_rdata, 16'h4321);
    tick;
    for (int i = 0; i < 5; i++) begin
      req(err_tab[i][16], err_tab[i][15:0], 16'hFFFF);
      tick;
      req_valid = 1'b0;
      chk("err_valid", rsp_valid, 1);
      chk("err_flag", rsp_err, 1);
      chk("err_rdata", rsp_rdata, 0);
      chk("err_no_fb_we", fb_we, 0);
      tick;
    end
    req(1'b1, 16'hF2BF, 16'hA55A);
    tick;
    req_valid = 1'b0;
    chk("fb_we", fb_we, 1);
    chk("fb_addr", fb_addr, 4799);
    chk("fb_data", fb_data, 8'h5A);
    chk("fb_rsp", rsp_valid, 1);
    chk("fb_err", rsp_err, 0);
    tick;
    chk("fb_we_drop", fb_we, 0);
    req(1'b1, 16'hF2C0, 16'h1111);
    tick;
    req_valid = 1'b0;
    chk("fb_oob_we", fb_we, 0);
    chk("fb_oob_err", rsp_err, 1);
    chk("fb_oob_addr", fb_addr, 4799);
    tick;
    req(1'b1, 16'h7FFF, 16'h1357);
    tick;
    req_valid = 1'b0;
    chk("wr_c1_en", ram_wr_enable, 0);
    tick;
    chk("wr_en", ram_wr_enable, 1);
    chk("wr_addr", ram_wr_addr, 25'h0007FFF);
    chk("wr_data", ram_wr_data, 16'h1357);
    chk("wr_c2_valid", rsp_valid, 0);
    tick;
    chk("wr_en_drop", ram_wr_enable, 0);
    chk("wr_rsp", rsp_valid, 1);
    chk("wr_err", rsp_err, 0);
    tick;
    req(1'b0, 16'h0123, 16'h0);
    en_cnt = 0; en_cyc = 0; rc = 0; ra = '0; rd = '0; er = 1'bx;
    for (int k = 1; k <= 30; k++) begin
      tick;
      req_valid = 1'b0;
      ram_busy = (k <= 3);
      if (ram_rd_enable) begin
        en_cnt++;
        en_cyc = k;
        ra = ram_rd_addr;
      end
      ram_rd_ready = (en_cyc != 0 && k == en_cyc + 4);
      ram_rd_data = 16'hBEEF;
      if (rsp_valid && rc == 0) begin
        rc = k; rd = rsp_rdata; er = rsp_err;
      end
    end
    ram_rd_ready = 1'b0;
    chk("rd_en_pulses", en_cnt, 1);
    chk("rd_en_cycle", en_cyc, 5);
    chk("rd_addr", ra, 25'h0000123);
    chk("rd_rsp_cycle", rc, 10);
    chk("rd_rdata", rd, 16'hBEEF);
    chk("rd_err", er, 0);
    req(1'b1, 16'hE010, 16'h0011);
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk("b2b_fb_we", fb_we, (k % 2 == 1));
      chk("b2b_ready", req_ready, (k % 2 == 0));
      if (k == 6) req_valid = 1'b0;
    end
    tick;
    req(1'b0, 16'h0040, 16'h0);
    tick;
    req_valid = 1'b0;
    tick;
    chk("rst_rd_en_before", ram_rd_enable, 1);
    tick;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_rd_addr", ram_rd_addr, 0);
    chk("rst_mid_rdata", rsp_rdata, 0);
    tick; tick;
    rst_n = 1'b1;
    ram_rd_ready = 1'b1;
    ram_rd_data = 16'h9999;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("rst_no_rsp", rsp_valid, 0);
    end
    ram_rd_ready = 1'b0;
    req(1'b0, 16'h0040, 16'h0);
    tick;
    req_valid = 1'b0;
    tick;
    chk("post_rst_rd_en", ram_rd_enable, 1);
    chk("post_rst_rd_addr", ram_rd_addr, 25'h40);
    tick;
    ram_rd_ready = 1'b1;
    ram_rd_data = 16'hCAFE;
    tick;
    ram_rd_ready = 1'b0;
    chk("post_rst_rsp", rsp_valid, 1);
    chk("post_rst_rdata", rsp_rdata, 16'hCAFE);
    chk("post_rst_err", rsp_err, 0);
    tick;
    for (int pass = 0; pass < 2; pass++) begin
      t_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0100;
      rc = 0; rd = 'x; er = 1'bx;
      for (int k = 1; k <= 12; k++) begin
        tick;
        t_valid = 1'b0;
        ram_rd_ready = (pass == 0 && k == 8);
        ram_rd_data = 16'h7777;
        if (t_rsp_valid && rc == 0) begin
          rc = k; rd = t_rsp_rdata; er = t_rsp_err;
        end
      end
      ram_rd_ready = 1'b0;
      chk("to_rsp_cycle", rc, 9);
      chk("to_rdata", rd, pass == 0 ? 16'h7777 : 16'h0);
      chk("to_err", er, pass);
    end
    ram_rd_ready = 1'b1;
    ram_rd_data = 16'h5555;
    for (int k = 0; k < 2; k++) begin
      tick;
      chk("late_ready_valid", t_rsp_valid, 0);
      chk("late_ready_rdata", t_rsp_rdata, 0);
      chk("late_ready_idle", t_req_ready, 1);
    end
    ram_rd_ready = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
